fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the next-generation core. It replaces the bare PC register and its direct combinational instruction-memory read with a request/grant/response memory port, up to DEPTH requests in flight, and a DEPTH-entry prefetch buffer. The buffer feeds decode through a valid/ready handshake. A redirect port takes branch/jump targets from execute and flushes the buffer and any stale in-flight fetches.

## Interface
- XLEN, 64: address/PC width.
- DEPTH, 4: prefetch buffer entries and maximum in-flight requests; power of two, ≥2.
- RESET_PC, 0: first fetch address after reset.

- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous and active-low
- fetch_en  in  1  1 = issue new requests; 0 = no new requests (responses still accepted)
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  request address = fetch_pc
- imem_gnt  in  1  request accepted when imem_req && imem_gnt
- imem_rvalid  in  1  response valid; in order, ≥1 cycle after its grant
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  new fetch target; bits [1:0] forced to 0
- if_valid  out  1  buffer head valid
- if_ready  in  1  decode accepts head when if_valid && if_ready
- if_pc  out  XLEN  PC of head entry
- if_instr  out  32  instruction of head entry

## Operation
- State: fetch_pc, resp_pc (PC of next kept response), inflight and drop_cnt counters (width clog2(DEPTH+1)), DEPTH-entry FIFO of {pc, instr} with count.
- imem_req = fetch_en && !redirect_valid && (count + inflight < DEPTH). imem_addr = fetch_pc.
- Grant: fetch_pc += 4 (mod 2^XLEN); inflight++.
- Response, drop_cnt > 0: drop_cnt--, inflight--, data discarded.
- Response, drop_cnt == 0: push {resp_pc, imem_rdata}; resp_pc += 4; inflight--.
- A grant and a response in the same cycle leave inflight unchanged.
- Pop on if_valid && if_ready. Push and pop in the same cycle leave count unchanged.
- Push when full cannot occur: the credit check guarantees it. The bench asserts this.
- Redirect cycle, redirect has priority over everything:
  - fetch_pc and resp_pc take {redirect_pc[XLEN-1:2], 2'b00}.
  - FIFO is emptied (count = 0), and a same-cycle pop has no effect.
  - imem_req is 0.
  - A response arriving in this cycle is discarded.
  - drop_cnt = inflight − (imem_rvalid ? 1 : 0). inflight keeps that same value.
- Back-to-back redirects: each recomputes drop_cnt from the current inflight. Only the last redirect target survives.
- fetch_en = 0 never drops data. Outstanding responses still complete into the buffer.
- if_pc/if_instr show the head entry. Their value is don't-care when if_valid = 0; the FIFO is cleared to 0 on reset.

## Timing
- Reset (rst_n = 0, asynchronous):
  - fetch_pc = resp_pc = RESET_PC.
  - inflight = drop_cnt = count = 0.
  - imem_req = 0 while rst_n is low; imem_addr = RESET_PC.
  - if_valid = 0, if_pc = 0, if_instr = 0.
- Reset mid-operation: all in-flight state is lost. The memory is reset by the same rst_n, so no stale responses arrive afterwards.
- Grant in cycle N gives the earliest rvalid in N+1. The entry is pushed at the end of the rvalid cycle, and if_valid rises the cycle after rvalid (earliest N+2). There is no response-to-decode bypass.
- Redirect in cycle R: if_valid = 0 in R+1. The first request to the new target is presented in R+1 when credit allows.
- Sustained throughput is 1 instruction/cycle when the memory grants every cycle and latency ≤ DEPTH−1.
- Outputs if_valid, if_pc and if_instr are registered, with no combinational path from imem_* to them. imem_req depends combinationally on redirect_valid and fetch_en.

## Test plan
- Reset, 1-cycle memory, if_ready = 1: imem_addr runs 0x0, 0x4, 0x8… and decode receives (0x0, I0), (0x4, I1)… with the first if_valid at cycle 2 after reset release, then one instruction per cycle.
- if_ready = 0 with an always-granting memory: requests stop after 4 (DEPTH = 4). count = 4, inflight = 0, imem_req = 0. Releasing if_ready drains 0x0–0xC in order, and requests resume.
- 3-cycle latency, 3 requests in flight (0x10, 0x14, 0x18), redirect_pc = 0x203:
  - drop_cnt = 3, and those 3 responses are discarded.
  - The next if_valid shows if_pc = 0x200 and imem_rdata of the 0x200 request.
- Redirect in the same cycle as a response and a pop: the response is discarded, the FIFO is empty next cycle, and drop_cnt = inflight − 1.
- fetch_en dropped with 2 in flight: both responses still reach decode, and no further imem_req appears until fetch_en = 1.
- Wrap-around with XLEN = 32 and RESET_PC = 0xFFFF_FFF8: fetch order is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. rst_n asserted mid-stream clears if_valid immediately, and fetch restarts at 0xFFFF_FFF8.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited request/grant/response memory port feeding a
// DEPTH-entry prefetch FIFO, with redirect flushing the buffer and stale in-flight responses.
module fetch_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0] fifo_pc_q    [DEPTH];
    logic [31:0]     fifo_instr_q [DEPTH];

    logic            grant, push, pop;
    logic [XLEN-1:0] redirect_tgt;
    logic [CW:0]     occupancy;
    logic            unused_pc_bits;

    assign redirect_tgt   = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Credit covers both buffered entries and outstanding requests, so a push never finds
    // the FIFO full.
    assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};
    assign imem_req  = rst_n && fetch_en && !redirect_valid && (occupancy < DepthW);
    assign imem_addr = fetch_pc_q;

    assign grant = imem_req && imem_gnt;
    assign push  = imem_rvalid && !redirect_valid && (drop_cnt_q == '0);
    assign pop   = if_valid && if_ready && !redirect_valid;

    assign if_valid = (count_q != '0);
    assign if_pc    = fifo_pc_q[rd_ptr_q];
    assign if_instr = fifo_instr_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Everything still outstanding belongs to the old path.
            inflight_d = inflight_q - CW'(imem_rvalid);
            drop_cnt_d = inflight_q - CW'(imem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid);
            if (imem_rvalid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                wr_ptr_d  = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else if (push) begin
            fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: in-order memory model with random latency, and a reference
// that tracks each request's address and delivers kept responses to decode in order.
module tb_fetch_unit;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    fetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ready;
        bit          stale;
    } req_t;

    req_t        pend[$];   // granted requests awaiting a response, oldest first
    logic [31:0] bufq[$];   // PCs the buffer should hold, head first
    logic [31:0] req_pc;
    int          cyc;
    int          last_ready;
    int          n_checks;
    int          n_pass;
    int          p_fetch, p_ready, p_gnt, p_redir, min_lat, max_lat;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic set_knobs(input int f, input int r, input int g, input int rd,
                             input int lmin, input int lmax);
        p_fetch = f; p_ready = r; p_gnt = g; p_redir = rd; min_lat = lmin; max_lat = lmax;
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        fetch_en       = 1'b1;
        imem_gnt       = 1'b1;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        rst_n          = 1'b0;
        #1;
        check_eq("rst_if_valid", if_valid, 0);
        check_eq("rst_imem_req", imem_req, 0);
        check_eq("rst_imem_addr", imem_addr, RESET_PC);
        check_eq("rst_if_pc", if_pc, 0);
        check_eq("rst_if_instr", if_instr, 0);
        repeat (hold) @(negedge clk);
        fetch_en = 1'b0;
        imem_gnt = 1'b0;
        rst_n    = 1'b1;
        pend.delete();
        bufq.delete();
        req_pc     = RESET_PC;
        last_ready = -1;
    endtask

    task automatic step(input bit force_red, input logic [31:0] force_tgt);
        bit          red, rv, exp_req;
        logic [31:0] tgt;
        int          lat;
        req_t        r;
        @(negedge clk);
        fetch_en = ($urandom_range(99) < p_fetch);
        if_ready = ($urandom_range(99) < p_ready);
        imem_gnt = ($urandom_range(99) < p_gnt);
        red      = force_red || ($urandom_range(999) < p_redir);
        tgt      = force_red ? force_tgt : $urandom;
        redirect_valid = red;
        redirect_pc    = tgt;
        rv = (pend.size() > 0) && (pend[0].ready <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? instr_of(pend[0].addr) : $urandom;
        #1;
        check_eq("if_valid", if_valid, bufq.size() > 0);
        if (bufq.size() > 0) begin
            check_eq("if_pc", if_pc, bufq[0]);
            check_eq("if_instr", if_instr, instr_of(bufq[0]));
        end
        exp_req = fetch_en && !red && (bufq.size() + pend.size() < DEPTH);
        check_eq("imem_req", imem_req, exp_req);
        if (exp_req) check_eq("imem_addr", imem_addr, req_pc);

        if (red) begin
            if (rv) void'(pend.pop_front());
            foreach (pend[i]) pend[i].stale = 1'b1;
            bufq.delete();
            req_pc = {tgt[31:2], 2'b00};
        end else begin
            if (bufq.size() > 0 && if_ready) void'(bufq.pop_front());
            if (rv) begin
                r = pend.pop_front();
                if (!r.stale) begin
                    check_eq("buf_room", bufq.size() < DEPTH, 1);
                    bufq.push_back(r.addr);
                end
            end
            // Grants follow the DUT's own request so over-issue shows up as buffer overflow.
            if (imem_req && imem_gnt) begin
                lat     = int'($urandom_range(max_lat, min_lat));
                r.addr  = req_pc;
                r.ready = (cyc + lat > last_ready + 1) ? cyc + lat : last_ready + 1;
                r.stale = 1'b0;
                last_ready = r.ready;
                pend.push_back(r);
                req_pc = req_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 32'h0);
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        cyc            = 0;
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        do_reset(2);

        set_knobs(100, 100, 100, 0, 1, 1);
        run(20);                         // streams across the 0xFFFF_FFFC -> 0x0 wrap
        set_knobs(100, 0, 100, 0, 1, 1);
        run(12);                         // buffer fills, requests stop
        set_knobs(100, 100, 100, 0, 1, 1);
        run(10);
        set_knobs(100, 100, 100, 0, 3, 3);
        run(8);
        step(1'b1, 32'h0000_0203);       // redirect with responses outstanding
        run(12);
        set_knobs(50, 80, 90, 0, 1, 4);
        run(200);
        set_knobs(100, 0, 100, 0, 1, 2);
        run(10);
        do_reset(3);                     // reset with a full buffer
        set_knobs(100, 100, 100, 0, 1, 1);
        run(10);
        set_knobs(85, 70, 70, 30, 1, 5);
        run(3000);
        set_knobs(90, 60, 80, 200, 1, 4);
        run(600);
        set_knobs(0, 100, 100, 0, 1, 4);
        run(20);                         // fetch off: outstanding work drains

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
